dlatch_bank_ctrl: RTL
=====================

// Module: dlatch_bank_ctrl
// PURPOSE
//   Sequences writes into a bank of NLATCH level-sensitive D latches (en/d/q cells).
//   Up to NREQ requesters share one d bus; a round-robin arbiter picks one write at a time.
//   Latch enables come only from flops, are one-hot and never glitch.
//   Setup and hold windows keep d stable around every enable pulse.
//   Sits between register-write masters and the latch storage array.
// PARAMETERS
//   NREQ     4  number of requesters
//   NLATCH   8  number of latches (or latch words) in the bank
//   DW       1  data width per latch word (1 = single dlatch cell)
//   OPEN_CYC 2  cycles lat_en is held high; legal range >=1
//   HOLD_CYC 2  cycles lat_d is held stable after lat_en falls; legal range >=1
//   AW       $clog2(NLATCH), derived, not overridable
// PORTS
//   clk     in   1          single clock, rising edge
//   rst     in   1          synchronous reset, active-high
//   req     in   NREQ       per-requester write request; level, held until ack
//   addr    in   NREQ*AW    per-requester latch index; slice i belongs to req[i]
//   wdata   in   NREQ*DW    per-requester write data; slice i belongs to req[i]
//   ack     out  NREQ       one-cycle completion pulse to the granted requester
//   err     out  1          pulses with ack when the captured addr >= NLATCH
//   busy    out  1          high whenever state != IDLE
//   lat_d   out  DW         shared latch data bus
//   lat_en  out  NLATCH     one-hot latch enables (all zero outside OPEN)
// BEHAVIOUR
//   Reset (sync, rst=1 at an edge): state=IDLE, ptr=0, cnt=0.
//     All outputs become 0 (ack, err, busy, lat_d, lat_en) at that same edge.
//     Reset during any state drops lat_en immediately; the in-flight write is abandoned with no ack.
//   All outputs are registered. No combinational path from any input to any output.
//   FSM: IDLE -> SETUP -> OPEN -> HOLD -> IDLE.
//   IDLE: if |req, the arbiter picks winner w.
//     Search starts at ptr and wraps NREQ-1 -> 0.
//     Capture w, addr[w] and wdata[w]. Next state is SETUP.
//   SETUP (1 cycle): lat_d = captured data; lat_en = 0.
//   OPEN (OPEN_CYC cycles): lat_en[addr] = 1; lat_d stays stable.
//     If addr >= NLATCH, lat_en stays 0.
//   HOLD (HOLD_CYC cycles): lat_en = 0; lat_d stays stable.
//     On the last HOLD cycle: ack[w] = 1, err = (addr >= NLATCH), ptr <= (w+1) mod NREQ.
//   After HOLD the FSM returns to IDLE. lat_d keeps its last value until the next SETUP.
//   Timing, with the accept edge = cycle 0:
//     SETUP in cycle 1; OPEN in cycles 2..OPEN_CYC+1; ack in cycle OPEN_CYC+HOLD_CYC+1.
//   Back-to-back: a pending req is accepted in the first IDLE cycle after ack.
//     Throughput is one write per OPEN_CYC+HOLD_CYC+2 cycles.
//   Handshake:
//     Inputs are sampled only at acceptance. Later changes to addr/wdata are ignored.
//     A requester may drop req after acceptance; its ack still pulses.
//     The requester must drop or renew req on the cycle after its ack.
//     If req is still high, it is treated as a new write.
//   Simultaneous requests: exactly one is granted per transaction. Losers wait, fairness is round-robin.
//   Requests that arrive while busy are held pending; none is lost as long as req stays high.
//   Invariants:
//     $onehot0(lat_en) holds in every cycle.
//     lat_en != 0 only in OPEN.
//     lat_d never changes while lat_en != 0 or during HOLD.
// STRUCTURE
//   Package dlatch_ctrl_pkg holds:
//     the state enum typedef (IDLE, SETUP, OPEN, HOLD);
//     the counter width function, $clog2(max(OPEN_CYC, HOLD_CYC)+1).
//   Sub-module rr_arbiter (NREQ):
//     inputs req and ptr; outputs a one-hot grant and its binary index.
//     It is purely combinational; the FSM registers its result.
//   Top level contains the FSM, the phase counter, capture registers and output flops.
// TESTING
//   (defaults, OPEN_CYC=2, HOLD_CYC=2, accept edge = cycle 0)
//   1. Single write: req=4'b0001, addr0=3, wdata0=1 ->
//      lat_d=1 from cycle 1; lat_en=8'h08 in cycles 2-3; ack=4'b0001 in cycle 5 only;
//      busy high in cycles 1-5.
//   2. Contention: req=4'b1010 held ->
//      req1 is acked first, then req3; ptr=0 after the second ack;
//      the two enables are separated by >= HOLD_CYC+1 idle-enable cycles.
//   3. Out-of-range address: non-power-of-2 NLATCH=6, addr=7 ->
//      lat_en stays 0 throughout; ack and err pulse together in cycle 5.
//   4. Data stability: wdata changes to 0 in cycle 3 of a write started with wdata=1 ->
//      lat_d stays 1 until the next SETUP.
//   5. Reset mid-OPEN: rst=1 in cycle 2 ->
//      all outputs 0 from cycle 3; no ack; a held req restarts from ptr=0.
//   6. Random soak, 10k cycles, all 4 requesters ->
//      the three invariants hold every cycle; every accepted req gets exactly one ack;
//      no requester waits more than NREQ transactions.

Source files
------------

// File: rtl/dlatch_ctrl_pkg.sv
// Shared types and sizing helpers for the latch-bank write controller.
package dlatch_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StOpen,
        StHold
    } state_e;

    // Width of the phase counter, sized for the longer of the OPEN and HOLD phases.
    function automatic int unsigned cnt_width(input int unsigned open_cyc,
                                              input int unsigned hold_cyc);
        int unsigned longest;
        longest = (open_cyc > hold_cyc) ? open_cyc : hold_cyc;
        return $clog2(longest + 1);
    endfunction

    // Index width that stays at least one bit wide for single-entry sets.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr, wrapping.
module rr_arbiter
    import dlatch_ctrl_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned PW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx
);

    logic        found;
    int unsigned slot;

    // Scan NREQ slots starting at ptr; the first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        slot  = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            slot = (32'(ptr) + i) % NREQ;
            if (!found && req[slot]) begin
                found       = 1'b1;
                grant[slot] = 1'b1;
                idx         = PW'(slot);
            end
        end
    end

endmodule

// File: rtl/dlatch_bank_ctrl.sv
// Write sequencer for a bank of level-sensitive latches: SETUP -> OPEN -> HOLD per write,
// with round-robin arbitration between requesters and glitch-free flop-driven enables.
module dlatch_bank_ctrl
    import dlatch_ctrl_pkg::*;
#(
    parameter  int unsigned NREQ     = 4,
    parameter  int unsigned NLATCH   = 8,
    parameter  int unsigned DW       = 1,
    parameter  int unsigned OPEN_CYC = 2,
    parameter  int unsigned HOLD_CYC = 2,
    localparam int unsigned AW       = idx_width(NLATCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]   ack,
    output logic              err,
    output logic              busy,
    output logic [DW-1:0]     lat_d,
    output logic [NLATCH-1:0] lat_en
);

    localparam int unsigned PW = idx_width(NREQ);
    localparam int unsigned CW = cnt_width(OPEN_CYC, HOLD_CYC);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     widx_q, widx_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     data_q, data_d;

    logic [NREQ-1:0]   ack_q, ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [NLATCH-1:0] en_q, en_d;

    logic [NREQ-1:0]   arb_grant;
    logic [PW-1:0]     arb_idx;
    logic              addr_oor;
    logic              last_hold_next;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign addr_oor = 32'(addr_q) >= NLATCH;

    // Next-state, phase counter and capture of the winning request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        widx_d  = widx_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StSetup;
                    widx_d  = arb_idx;
                    grant_d = arb_grant;
                    addr_d  = addr[arb_idx*AW +: AW];
                    data_d  = wdata[arb_idx*DW +: DW];
                end
            end
            StSetup: begin
                state_d = StOpen;
                cnt_d   = '0;
            end
            StOpen: begin
                if (cnt_q == CW'(OPEN_CYC - 1)) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == CW'(HOLD_CYC - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    ptr_d   = (widx_q == PW'(NREQ - 1)) ? '0 : widx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output values are decoded from the next state so every output is a plain flop.
    always_comb begin
        last_hold_next = (state_d == StHold) && (cnt_d == CW'(HOLD_CYC - 1));
        busy_d         = (state_d != StIdle);
        en_d           = '0;
        if (state_d == StOpen && !addr_oor) begin
            en_d = NLATCH'(1) << addr_q;
        end
        ack_d = last_hold_next ? grant_q : '0;
        err_d = last_hold_next && addr_oor;
    end

    // State, capture and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= '0;
            widx_q  <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            widx_q  <= widx_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            en_q    <= en_d;
        end
    end

    assign ack    = ack_q;
    assign err    = err_q;
    assign busy   = busy_q;
    assign lat_d  = data_q;
    assign lat_en = en_q;

endmodule
